counter_ramp_ctrl: RTL and testbench
====================================

# counter_ramp_ctrl

Command-side controller for the 5-bit up/down saturating counter. Accepts a target value over a valid/ready request port and drives the counter's `in`/`load`/`up`/`down` inputs. The target is reached in one of two ways: an immediate load (jump mode), or a paced ramp of single ±1 steps. The block checks the counter's returned value after every command and reports completion, with an error flag if the counter did not respond as commanded.

## Interface
- `WIDTH`, 5: counter width; `cnt_*` and `req_target` widths.
- `DIV_W`, 8: width of step-interval field.

- `clock` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle, request accepted on `req_valid && req_ready`.
- `req_target` in WIDTH: target count.
- `req_mode` in 1: 0 = ramp, 1 = jump (load).
- `req_div` in DIV_W: extra idle cycles between ramp steps.
- `abort` in 1: terminate active request.
- `cnt_value` in WIDTH: counter's `counter` output.
- `cnt_high` in 1: counter's `high` flag, value 31.
- `cnt_low` in 1: counter's `low` flag, value 0.
- `cnt_in` out WIDTH: drives counter `in`.
- `cnt_load` out 1: drives counter `load`.
- `cnt_up` out 1: drives counter `up`.
- `cnt_down` out 1: drives counter `down`.
- `busy` out 1: request in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = abort or counter mismatch.

## Operation
- **States:** IDLE, JUMP, WAIT, STEP, SETTLE, DONE.
- **Reset:**
  - state = IDLE.
  - `cnt_load`, `cnt_up`, `cnt_down`, `busy`, `done`, `err` = 0.
  - `cnt_in` = 0.
  - `req_ready` = 0 while `rst` is high, and 1 in IDLE thereafter.
- **IDLE:**
  - On accept, latch `target`, `mode`, `div`.
  - Jump mode goes to JUMP.
  - Ramp mode with `target == cnt_value` goes to DONE (zero steps).
  - Otherwise go to WAIT with `timer = div`.
- **JUMP:**
  - `cnt_load = 1` and `cnt_in = target` for exactly one cycle.
  - Set `expected = target`, then go to SETTLE.
- **WAIT:**
  - If `timer == 0`, go to STEP; else `timer -= 1`.
  - WAIT lasts `div + 1` cycles.
- **STEP:**
  - Exactly one cycle.
  - If `target > cnt_value`: `cnt_up = 1`, `expected = cnt_value + 1`.
  - Otherwise: `cnt_down = 1`, `expected = cnt_value - 1`.
  - Never assert `cnt_up` while `cnt_high` is set, nor `cnt_down` while `cnt_low` is set. This cannot occur for a legal target.
  - Go to SETTLE.
- **SETTLE:**
  - If `cnt_value != expected`, go to DONE with `err = 1`.
  - Else if `cnt_value == target`, go to DONE with `err = 0`.
  - Else go to WAIT with `timer = div`.
- **DONE:** `done = 1` for one cycle, `err` held for that cycle, then go to IDLE.
- **`busy`:** 1 in every state except IDLE.
- **`cnt_load`/`cnt_up`/`cnt_down`:** decoded from state and direction. At most one is high in any cycle.
- **`cnt_in`:** holds the latched `target` outside JUMP.
- **`abort`:**
  - Ignored in IDLE and DONE.
  - In any other state, go to DONE with `err = 1`. No counter command is issued in that cycle.
- **Priority:** `rst` > `abort` > normal transitions.
- **Width rules:**
  - Compare `target` and `cnt_value` unsigned, WIDTH bits.
  - `expected` arithmetic is WIDTH bits. No wrap is reachable on a legal path.
  - `timer` is DIV_W bits.

## Timing
- Request accepted at edge E0; cycle n is the n-th cycle after E0.
- Jump mode: JUMP in cycle 1, SETTLE in cycle 2, `done` in cycle 3.
- Ramp mode, zero steps: `done` in cycle 1.
- Ramp mode, n steps: `done` in cycle `1 + n*(div+3)`.
- Step rate: one ±1 per `div + 3` cycles.
- New request is accepted the cycle after DONE, so back-to-back request spacing is ≥ 1 idle cycle.
- Reset asserted mid-operation: outputs at reset values from the next edge. A command already issued in that cycle is not retracted.

## Structure
- Package `counter_ctrl_pkg` holds:
  - the state encoding (6 states, 3-bit);
  - `CNT_WIDTH = 5`;
  - `CNT_MAX = 5'b11111`.
- Sub-module `step_timer`:
  - DIV_W-bit loadable down-counter with `load`, `value` and `zero` outputs;
  - used by the WAIT state.

## Test plan
- Reset, then counter = 3; ramp to 5 with `div = 0`. Required: `cnt_up` pulses in cycles 2 and 5; `done = 1`, `err = 0` in cycle 7; counter = 5.
- Counter = 20; jump to 7. Required: `cnt_load = 1` with `cnt_in = 7` in cycle 1; `done = 1`, `err = 0` in cycle 3.
- Counter = 1; ramp to 0 with `div = 4`. Required: `cnt_down` in cycle 6; `done` in cycle 8; `cnt_low` = 1 afterwards.
- Ramp 0 → 31 with `div = 0`. Required: 31 `cnt_up` pulses; `done` in cycle 94; `cnt_up` never asserted while `cnt_high = 1`.
- Ramp 10 → 20, forcing the counter's `load` externally mid-ramp so `cnt_value` jumps to 25. Required: next SETTLE sees a mismatch; `done = 1`, `err = 1`.
- Ramp 0 → 15, `abort` in cycle 4. Required: `done = 1`, `err = 1` in cycle 5. Separately, `rst` in WAIT gives all outputs 0 the next cycle and `req_ready = 1` after `rst` deasserts.

Source files
------------

// File: rtl/counter_ramp_ctrl_pkg.sv
// Shared types and constants for the counter ramp controller.
//   state_e   : controller FSM encoding (6 states, 3 bits)
//   CNT_WIDTH : width of the controlled up/down counter
//   CNT_MAX   : counter saturation value
//   DIV_WIDTH : width of the ramp step-interval field
package counter_ctrl_pkg;

    localparam int unsigned CNT_WIDTH = 5;
    localparam int unsigned DIV_WIDTH = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_JUMP   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STEP   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/counter_ramp_ctrl_if.sv
// Request channel plus counter command/status bundle.
//   master : requester / counter side (drives request and counter status)
//   slave  : controller side (accepts request, drives counter commands)
interface counter_ramp_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH,
    parameter int unsigned DIV_W = DIV_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;
    logic             req_mode;
    logic [DIV_W-1:0] req_div;

    logic [WIDTH-1:0] cnt_value;
    logic             cnt_high;
    logic             cnt_low;
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_load;
    logic             cnt_up;
    logic             cnt_down;

    modport master (
        output req_valid, req_target, req_mode, req_div,
        output cnt_value, cnt_high, cnt_low,
        input  req_ready, cnt_in, cnt_load, cnt_up, cnt_down
    );

    modport slave (
        input  req_valid, req_target, req_mode, req_div,
        input  cnt_value, cnt_high, cnt_low,
        output req_ready, cnt_in, cnt_load, cnt_up, cnt_down
    );
endinterface

// File: rtl/counter_ramp_ctrl_step_timer.sv
// Loadable down-counter pacing the ramp WAIT state.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one
//   value_o    : current count
//   zero_o     : registered flag, count == 0
module step_timer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [DIV_W-1:0] value_o,
    output logic             zero_o
);
    logic [DIV_W-1:0] value_q;
    logic             zero_q;

    // zero flag is computed alongside the count so it stays registered
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            zero_q  <= 1'b1;
        end else if (load_i) begin
            value_q <= load_val_i;
            zero_q  <= (load_val_i == '0);
        end else if (dec_i) begin
            value_q <= value_q - DIV_W'(1);
            zero_q  <= (value_q == DIV_W'(1));
        end
    end

    assign value_o = value_q;
    assign zero_o  = zero_q;
endmodule

// File: rtl/counter_ramp_ctrl.sv
// Command-side controller for a 5-bit up/down saturating counter.
// Accepts a target over a valid/ready port and reaches it either by a
// single load (jump) or by paced +/-1 steps (ramp), verifying the
// counter's returned value after every command.
//   clock, rst : clock, synchronous active-high reset
//   bus        : request channel and counter command/status (slave side)
//   abort      : terminate the active request (done with err)
//   busy       : request in progress
//   done       : one-cycle completion pulse
//   err        : qualifies done; abort or counter mismatch
module counter_ramp_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH,
    parameter int unsigned DIV_W = DIV_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst,
    counter_ramp_ctrl_if.slave    bus,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    state_e           state_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] expected_q;
    logic [DIV_W-1:0] div_q;
    logic             req_ready_q;
    logic             cnt_load_q;
    logic             cnt_up_q;
    logic             cnt_down_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             accept_c;
    logic             abortable_c;
    logic             tmr_load_c;
    logic             tmr_dec_c;
    logic [DIV_W-1:0] tmr_val_c;
    logic [DIV_W-1:0] tmr_value;
    logic             tmr_zero;

    assign accept_c    = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;
    assign abortable_c = abort && (state_q inside {ST_JUMP, ST_WAIT, ST_STEP, ST_SETTLE});

    // Timer is reloaded in every non-WAIT state, so it always enters WAIT
    // holding div; in IDLE the request field is used directly since div_q
    // is latched on that same edge.
    assign tmr_load_c = (state_q != ST_WAIT);
    assign tmr_val_c  = (state_q == ST_IDLE) ? bus.req_div : div_q;
    assign tmr_dec_c  = (state_q == ST_WAIT) && (tmr_value != '0);

    step_timer #(.DIV_W(DIV_W)) u_step_timer (
        .clk        (clock),
        .rst        (rst),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .dec_i      (tmr_dec_c),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    // FSM; outputs are registered from the next state, so commands appear
    // in the same cycle as the state that issues them.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            expected_q  <= '0;
            div_q       <= '0;
            req_ready_q <= 1'b0;
            cnt_load_q  <= 1'b0;
            cnt_up_q    <= 1'b0;
            cnt_down_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_load_q  <= 1'b0;
            cnt_up_q    <= 1'b0;
            cnt_down_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;

            if (abortable_c) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        req_ready_q <= 1'b1;
                        if (accept_c) begin
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            target_q    <= bus.req_target;
                            div_q       <= bus.req_div;
                            if (bus.req_mode) begin
                                state_q    <= ST_JUMP;
                                cnt_load_q <= 1'b1;
                            end else if (bus.req_target == bus.cnt_value) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                    ST_JUMP: begin
                        expected_q <= target_q;
                        state_q    <= ST_SETTLE;
                    end
                    ST_WAIT: begin
                        if (tmr_zero) begin
                            state_q <= ST_STEP;
                            // saturated counter must never be pushed further
                            if (target_q > bus.cnt_value) begin
                                cnt_up_q   <= !bus.cnt_high;
                                expected_q <= bus.cnt_value + WIDTH'(1);
                            end else begin
                                cnt_down_q <= !bus.cnt_low;
                                expected_q <= bus.cnt_value - WIDTH'(1);
                            end
                        end
                    end
                    ST_STEP: begin
                        state_q <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (bus.cnt_value != expected_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (bus.cnt_value == target_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_DONE: begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.cnt_in    = target_q;
    assign bus.cnt_load  = cnt_load_q;
    assign bus.cnt_up    = cnt_up_q;
    assign bus.cnt_down  = cnt_down_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_counter_ramp_ctrl.sv
// Directed bench for counter_ramp_ctrl with a behavioural saturating counter.
module tb_counter_ramp_ctrl;
    import counter_ctrl_pkg::*;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic abort = 1'b0;
    logic busy, done, err;

    counter_ramp_ctrl_if #(.WIDTH(5), .DIV_W(8)) bus ();

    counter_ramp_ctrl #(.WIDTH(5), .DIV_W(8)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clock = ~clock;

    // Counter under control; ext_load models an outside agent loading it.
    logic [4:0] cnt_q    = 5'd0;
    logic       ext_load = 1'b0;
    logic [4:0] ext_val  = 5'd0;
    always @(posedge clock) begin
        if (ext_load)                        cnt_q <= ext_val;
        else if (bus.cnt_load)               cnt_q <= bus.cnt_in;
        else if (bus.cnt_up && cnt_q != 31)  cnt_q <= cnt_q + 5'd1;
        else if (bus.cnt_down && cnt_q != 0) cnt_q <= cnt_q - 5'd1;
    end
    assign bus.cnt_value = cnt_q;
    assign bus.cnt_high  = (cnt_q == 5'd31);
    assign bus.cnt_low   = (cnt_q == 5'd0);

    // Illegal command combinations seen at any edge
    int viol = 0;
    always @(posedge clock) begin
        if (bus.cnt_up && bus.cnt_high) viol++;
        if (bus.cnt_down && bus.cnt_low) viol++;
        if (32'(bus.cnt_load) + 32'(bus.cnt_up) + 32'(bus.cnt_down) > 1) viol++;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to cycle n after the accepting edge, sampled 1ns after the edge
    task automatic adv(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic preset(input logic [4:0] v);
        @(negedge clock);
        ext_val  = v;
        ext_load = 1'b1;
        @(posedge clock);
        #1;
        ext_load = 1'b0;
    endtask

    // Present a request and return sampled in cycle 1
    task automatic send(input logic [4:0] t, input logic m, input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            ok = bus.req_ready;
        end
        check("req_ready_wait", 32'(ok), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_target = t;
        bus.req_mode   = m;
        bus.req_div    = d;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        cyc = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ups;
        bus.req_valid  = 1'b0;
        bus.req_target = 5'd0;
        bus.req_mode   = 1'b0;
        bus.req_div    = 8'd0;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_cmd",   32'({bus.cnt_load, bus.cnt_up, bus.cnt_down}), 32'd0);
        check("rst_in",    32'(bus.cnt_in), 32'd0);
        rst = 1'b0;

        // Ramp 3 -> 5, div 0: ups in cycles 2 and 5, done in 7
        preset(5'd3);
        send(5'd5, 1'b0, 8'd0);
        check("r1_c1_busy", 32'(busy), 32'd1);
        check("r1_c1_up",   32'(bus.cnt_up), 32'd0);
        check("r1_c1_in",   32'(bus.cnt_in), 32'd5);
        adv(2); check("r1_c2_up", 32'(bus.cnt_up), 32'd1);
        check("r1_c2_dn", 32'(bus.cnt_down), 32'd0);
        adv(3); check("r1_c3_up", 32'(bus.cnt_up), 32'd0);
        adv(5); check("r1_c5_up", 32'(bus.cnt_up), 32'd1);
        adv(6); check("r1_c6_done", 32'(done), 32'd0);
        adv(7); check("r1_c7_done", 32'(done), 32'd1);
        check("r1_c7_err", 32'(err), 32'd0);
        check("r1_cnt",    32'(cnt_q), 32'd5);
        adv(8); check("r1_c8_done", 32'(done), 32'd0);
        check("r1_c8_busy", 32'(busy), 32'd0);

        // Jump 20 -> 7
        preset(5'd20);
        send(5'd7, 1'b1, 8'd9);
        check("j_c1_load", 32'(bus.cnt_load), 32'd1);
        check("j_c1_in",   32'(bus.cnt_in), 32'd7);
        adv(2); check("j_c2_load", 32'(bus.cnt_load), 32'd0);
        adv(3); check("j_c3_done", 32'(done), 32'd1);
        check("j_c3_err",   32'(err), 32'd0);
        check("j_c3_ready", 32'(bus.req_ready), 32'd0);
        check("j_cnt",      32'(cnt_q), 32'd7);
        adv(4); check("j_c4_ready", 32'(bus.req_ready), 32'd1);

        // Zero-step ramp: done in cycle 1
        send(5'd7, 1'b0, 8'd3);
        check("z_c1_done", 32'(done), 32'd1);
        check("z_c1_err",  32'(err), 32'd0);

        // Ramp 1 -> 0, div 4: down in cycle 6, done in 8
        preset(5'd1);
        send(5'd0, 1'b0, 8'd4);
        adv(5); check("d_c5_dn", 32'(bus.cnt_down), 32'd0);
        adv(6); check("d_c6_dn", 32'(bus.cnt_down), 32'd1);
        adv(7); check("d_c7_done", 32'(done), 32'd0);
        adv(8); check("d_c8_done", 32'(done), 32'd1);
        check("d_c8_err", 32'(err), 32'd0);
        adv(9); check("d_low", 32'(bus.cnt_low), 32'd1);

        // Full ramp 0 -> 31, div 0: 31 ups, done in cycle 94
        send(CNT_MAX, 1'b0, 8'd0);
        ups = 0;
        for (int c = 1; c <= 93; c++) begin
            adv(c);
            if (bus.cnt_up) ups++;
        end
        check("f_c93_done", 32'(done), 32'd0);
        check("f_ups", 32'(ups), 32'd31);
        adv(94); check("f_c94_done", 32'(done), 32'd1);
        check("f_c94_err", 32'(err), 32'd0);
        check("f_cnt", 32'(cnt_q), 32'(CNT_MAX));

        // Ramp 10 -> 20 with an external load to 25 during cycle 4
        preset(5'd10);
        send(5'd20, 1'b0, 8'd0);
        adv(4);
        ext_val  = 5'd25;
        ext_load = 1'b1;
        adv(5);
        ext_load = 1'b0;
        check("m_c5_up", 32'(bus.cnt_up), 32'd1);
        adv(6); check("m_c6_done", 32'(done), 32'd0);
        adv(7); check("m_c7_done", 32'(done), 32'd1);
        check("m_c7_err", 32'(err), 32'd1);

        // Ramp 0 -> 15, abort in cycle 4: done/err in cycle 5, no step
        preset(5'd0);
        send(5'd15, 1'b0, 8'd0);
        adv(4);
        abort = 1'b1;
        adv(5);
        abort = 1'b0;
        check("a_c5_done", 32'(done), 32'd1);
        check("a_c5_err",  32'(err), 32'd1);
        check("a_c5_up",   32'(bus.cnt_up), 32'd0);
        adv(6); check("a_c6_busy", 32'(busy), 32'd0);
        check("a_c6_ready", 32'(bus.req_ready), 32'd1);
        check("a_cnt", 32'(cnt_q), 32'd1);

        // Abort while idle is ignored
        abort = 1'b1;
        adv(7);
        abort = 1'b0;
        check("ai_done", 32'(done), 32'd0);
        check("ai_ready", 32'(bus.req_ready), 32'd1);

        // Reset during WAIT
        send(5'd9, 1'b0, 8'd5);
        adv(2);
        check("w_c2_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        adv(3);
        check("w_rst_busy",  32'(busy), 32'd0);
        check("w_rst_ready", 32'(bus.req_ready), 32'd0);
        check("w_rst_flags", 32'({done, err}), 32'd0);
        check("w_rst_cmd",   32'({bus.cnt_load, bus.cnt_up, bus.cnt_down}), 32'd0);
        check("w_rst_in",    32'(bus.cnt_in), 32'd0);
        rst = 1'b0;
        adv(4);
        check("w_ready", 32'(bus.req_ready), 32'd1);
        check("w_busy",  32'(busy), 32'd0);

        check("cmd_violations", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
